// File: rtl/ir_sequencer_if.sv
// ir_sequencer_if: control bundle between the sequencer and the memory/IR/PC/register-file datapath
interface ir_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [15:0] Ir;
  logic MemReady, Stall, BranchTaken;
  logic MemRead, MemWrite, IrWe, ImmSel, PcWe, PcSel, RegWe, Halted, Fault;
  logic [CNT_W-1:0] InstrCount;
  modport master (
    input  Ir, MemReady, Stall, BranchTaken,
    output MemRead, MemWrite, IrWe, ImmSel, PcWe, PcSel, RegWe, Halted, Fault, InstrCount
  );
  modport slave (
    output Ir, MemReady, Stall, BranchTaken,
    input  MemRead, MemWrite, IrWe, ImmSel, PcWe, PcSel, RegWe, Halted, Fault, InstrCount
  );
endinterface

// File: rtl/ir_sequencer.sv
// ir_sequencer: multi-cycle fetch/decode/execute control FSM; define FETCH_TIMEOUT_EN for a memory-wait timeout fault
module ir_sequencer #(
  parameter int OPC_W = 4,
  parameter int CNT_W = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic Clock,
  input logic nReset,
  ir_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB, HALT} state_t;
  localparam logic [OPC_W-1:0] OP_IMM = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_LD  = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_ST  = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_BR  = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_NOP = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(15);
  state_t state, state_n;
  logic [OPC_W-1:0] opc;
  logic [CNT_W-1:0] count;
  logic imm_sel, retire, unused_ir;
  assign opc = bus.Ir[15 -: OPC_W];
  assign unused_ir = ^bus.Ir[15-OPC_W:0];
  assign bus.ImmSel = imm_sel;
  assign bus.InstrCount = count;
  assign bus.Halted = state == HALT;
`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wcnt;
  logic fault, req, timeout;
  assign req = (state == FETCH && !bus.Stall) || state == MEM_RD || state == MEM_WR;
  assign timeout = req && !bus.MemReady && wcnt == TO_LAST;
  assign bus.Fault = fault;
  // Wait counter restarts whenever a wait state is entered; Stall cycles carry no request and do not count
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      wcnt <= '0;
      fault <= 1'b0;
    end else begin
      wcnt <= state_n != state ? '0 : (req && !bus.MemReady) ? wcnt + 1'b1 : wcnt;
      fault <= fault | timeout;
    end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign bus.Fault = 1'b0;
`endif
  // State register, latched immediate format and retired-instruction counter
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      state <= IDLE;
      imm_sel <= 1'b0;
      count <= '0;
    end else begin
      state <= state_n;
      if (state == DECODE) imm_sel <= opc >= OP_IMM && opc <= OP_ST;
      if (retire) count <= count + 1'b1;
    end
  // Next state and control strobes; only FETCH's IrWe/PcWe look at MemReady combinationally
  always_comb begin
    state_n = state;
    retire = 1'b0;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IrWe = 1'b0;
    bus.PcWe = 1'b0;
    bus.PcSel = 1'b0;
    bus.RegWe = 1'b0;
    case (state)
      IDLE: state_n = FETCH;
      FETCH:
        if (!bus.Stall) begin
          bus.MemRead = 1'b1;
          bus.IrWe = bus.MemReady;
          bus.PcWe = bus.MemReady;
          state_n = bus.MemReady ? DECODE : FETCH;
        end
      DECODE: begin
        state_n = opc == OP_NOP ? FETCH : opc == OP_HLT ? HALT : EXEC;
        retire = opc == OP_NOP;
      end
      EXEC: begin
        bus.PcWe = opc == OP_JMP || (opc == OP_BR && bus.BranchTaken);
        bus.PcSel = opc == OP_JMP || (opc == OP_BR && bus.BranchTaken);
        state_n = opc == OP_LD ? MEM_RD : opc == OP_ST ? MEM_WR :
                  (opc == OP_JMP || opc == OP_BR) ? FETCH : WB;
        retire = opc == OP_JMP || opc == OP_BR;
      end
      MEM_RD: begin
        bus.MemRead = 1'b1;
        state_n = bus.MemReady ? WB : MEM_RD;
      end
      MEM_WR: begin
        bus.MemWrite = 1'b1;
        state_n = bus.MemReady ? FETCH : MEM_WR;
        retire = bus.MemReady;
      end
      WB: begin
        bus.RegWe = 1'b1;
        state_n = FETCH;
        retire = 1'b1;
      end
      HALT: state_n = HALT;
      default: state_n = IDLE;
    endcase
`ifdef FETCH_TIMEOUT_EN
    if (timeout) state_n = HALT;
`endif
  end
endmodule
